regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file; next generation of the CPU's 2-read/1-write register file.
- Adds configurable width, depth and port counts, and a hardwired zero register.
- Adds same-cycle write-to-read bypass and a per-register pending (scoreboard) bit for in-flight producers.
- Adds a sequenced bulk-clear engine with a busy/done handshake.
- Sits between the decode/issue stage (reads, issue marks) and the writeback stage (writes).

Parameters:
- DW, 32, data width in bits
- DEPTH, 64, number of registers (power of two, at least 4)
- AW, $clog2(DEPTH), address width (derived; do not override)
- NR, 2, number of read ports (1..4)
- NW, 2, number of write ports (1..2)
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and issue marks
- BYPASS, 1, when 1, same-cycle write data is forwarded to matching read ports

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- we  in  NW  per-port write enable
- wa  in  NW x AW  write addresses
- wd  in  NW x DW  write data
- ra  in  NR x AW  read addresses
- rd  out  NR x DW  read data
- rd_pend  out  NR  pending bit for each read address
- iss_v  in  1  issue mark valid
- iss_a  in  AW  destination register to mark pending
- clr_req  in  1  request a bulk clear (single-cycle pulse or level)
- clr_busy  out  1  high while the sweep is running
- clr_done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset (rst low, asynchronous):
  - All registers and pending bits become 0.
  - FSM goes to IDLE; clr_busy=0, clr_done=0.
  - rd/rd_pend reflect the cleared array (0 for every address).
- Writes: committed on the rising clk edge.
  - If several enabled ports target the same address, the highest port index wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Reads: combinational, zero-cycle latency.
  - With BYPASS=1, when any enabled write targets ra[i] this cycle, rd[i] = wd of the highest matching port.
  - With BYPASS=0, rd[i] shows the old value until the next cycle.
  - With ZERO_REG=1, address 0 always reads 0 and rd_pend=0.
- Pending bits:
  - iss_v sets pend[iss_a] on the edge.
  - Any enabled write to an address clears its bit on the edge.
  - Issue and write to the same address in the same cycle: set wins (new producer supersedes).
  - rd_pend[i] = pend[ra[i]], except that with BYPASS=1 it reads 0 when a same-cycle write matches ra[i] and iss_a does not.
- Clear FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP when clr_req=1; the counter loads 0.
  - SWEEP: each cycle, entry[cnt] and pend[cnt] are zeroed and cnt increments. clr_busy=1.
  - SWEEP: we and iss_v are ignored (masked) and bypass is disabled; reads return current array contents.
  - SWEEP -> DONE after clearing entry DEPTH-1. cnt wraps to 0 and must not alias.
  - DONE: clr_done=1 for exactly one cycle, clr_busy=0; then -> IDLE.
  - clr_req during SWEEP or DONE is ignored. Leaving clr_req at level re-triggers from IDLE.
  - Total latency: clr_req edge to clr_done = DEPTH+1 cycles.
  - Reset asserted mid-sweep aborts immediately to IDLE with the full array cleared.
- Widths: all data is unsigned DW-bit and is stored without modification; there is no arithmetic on data.

Decomposition:
- Package regfile_pkg holds:
  - enum rf_clr_state_t {IDLE, SWEEP, DONE}
  - default constants RF_DW=32, RF_DEPTH=64
- One sub-module, rf_clr_seq: the clear FSM plus the AW-bit sweep counter.
  - Outputs: clr_busy, clr_done, sweep_en, sweep_addr.
- Storage, write arbitration, bypass and scoreboard logic live in the top module.

Test Plan:
- Reset, then write 0xDEADBEEF to r5 via port 0 and 0x12345678 to r5 via port 1 in the same cycle -> rd of r5 is 0x12345678 in that cycle (bypass) and after the edge.
- ZERO_REG=1: write 0xFFFFFFFF to r0 with iss_v on r0 -> rd=0 and rd_pend=0 forever.
- iss_v to r7; next cycle rd_pend(r7)=1; write r7=0xA5 -> rd_pend=0 in that cycle (bypass) and after the edge.
- Issue and write r9 in the same cycle -> pend[r9]=1 after the edge.
- Fill all 64 regs, pulse clr_req -> clr_busy high for 64 cycles, clr_done pulses at cycle 65, every register reads 0.
- Writes during the sweep are ignored; drop rst low mid-sweep at cnt=20 -> all outputs 0 and FSM in IDLE immediately, asynchronously.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared types and default constants for the multi-port register file.
//   rf_clr_state_t : states of the bulk-clear sequencer
//   RF_DW          : default data width
//   RF_DEPTH       : default number of registers
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } rf_clr_state_t;

endpackage : regfile_pkg

// File: rtl/rf_clr_seq.sv
// ---------------------------------------------------------------------------
// rf_clr_seq
// Bulk-clear sequencer: walks an AW-bit counter over every register index,
// one index per cycle, then pulses a completion strobe.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   clr_req_i    : clear request, sampled only in IDLE
//   clr_busy_o   : high while the sweep is running
//   clr_done_o   : one-cycle pulse after the last index is cleared
//   sweep_en_o   : zero the entry at sweep_addr_o this cycle
//   sweep_addr_o : index being cleared this cycle
// ---------------------------------------------------------------------------
module rf_clr_seq
  import regfile_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req_i,
  output logic          clr_busy_o,
  output logic          clr_done_o,
  output logic          sweep_en_o,
  output logic [AW-1:0] sweep_addr_o
);

  // Depth is a power of two, so the last index is all ones. The exit test
  // looks at the counter value itself, so its wrap back to 0 on the same
  // edge never re-enters the sweep.
  localparam logic [AW-1:0] LAST_ADDR = '1;

  rf_clr_state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves a value held and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_busy_o = 1'b0;
    clr_done_o = 1'b0;
    sweep_en_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        clr_busy_o = 1'b1;
        sweep_en_o = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Requests arriving here are dropped; a held level re-arms from IDLE.
        clr_done_o = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sweep_addr_o = cnt_q;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : rf_clr_seq

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port register file with optional hardwired zero
// register, same-cycle write-to-read bypass, per-register pending bits for
// in-flight producers, and a sequenced bulk clear.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset (clears array and pending bits)
//   we/wa/wd : NW write ports (enable, address, data); highest index wins
//   ra/rd    : NR combinational read ports
//   rd_pend  : pending bit of each read address
//   iss_v/iss_a : mark a destination register pending
//   clr_req  : start a bulk clear
//   clr_busy : sweep in progress
//   clr_done : one-cycle pulse at sweep completion
// ---------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int DEPTH    = RF_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NW-1:0]          we,
  input  logic [NW-1:0][AW-1:0]  wa,
  input  logic [NW-1:0][DW-1:0]  wd,
  input  logic [NR-1:0][AW-1:0]  ra,
  output logic [NR-1:0][DW-1:0]  rd,
  output logic [NR-1:0]          rd_pend,
  input  logic                   iss_v,
  input  logic [AW-1:0]          iss_a,
  input  logic                   clr_req,
  output logic                   clr_busy,
  output logic                   clr_done
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;

  logic          sweep_en;
  logic [AW-1:0] sweep_addr;

  logic [NW-1:0] wr_en;
  logic          iss_en;
  logic [NR-1:0] byp_hit;

  // -------------------------------------------------------------------------
  // Clear sequencer
  // -------------------------------------------------------------------------
  rf_clr_seq #(
    .AW (AW)
  ) u_clr_seq (
    .clk          (clk),
    .rst_n        (rst),
    .clr_req_i    (clr_req),
    .clr_busy_o   (clr_busy),
    .clr_done_o   (clr_done),
    .sweep_en_o   (sweep_en),
    .sweep_addr_o (sweep_addr)
  );

  // -------------------------------------------------------------------------
  // Effective write / issue enables: the sweep owns the array, and the zero
  // register silently absorbs writes and issue marks.
  // -------------------------------------------------------------------------
  always_comb begin
    wr_en = '0;
    for (int p = 0; p < NW; p++) begin
      wr_en[p] = we[p] && !sweep_en && !((ZERO_REG != 0) && (wa[p] == '0));
    end
    iss_en = iss_v && !sweep_en && !((ZERO_REG != 0) && (iss_a == '0));
  end

  // -------------------------------------------------------------------------
  // Next-state of array and scoreboard. Ports are applied in ascending order
  // so the highest matching port overwrites lower ones; the issue mark is
  // applied last so a new producer supersedes a same-cycle writeback.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;

    if (sweep_en) begin
      mem_d[sweep_addr]  = '0;
      pend_d[sweep_addr] = 1'b0;
    end

    for (int p = 0; p < NW; p++) begin
      if (wr_en[p]) begin
        mem_d[wa[p]]  = wd[p];
        pend_d[wa[p]] = 1'b0;
      end
    end

    if (iss_en) begin
      pend_d[iss_a] = 1'b1;
    end
  end

  // NOTE: the array is built from flops, not a macro, because reset must
  // clear every entry at once; a real SRAM could only be cleared by the sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_q[a] <= '0;
      end
      pend_q <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports. wr_en is already forced low during the sweep, so the bypass
  // naturally turns off and reads see the array as it stands.
  // -------------------------------------------------------------------------
  always_comb begin
    byp_hit = '0;
    rd      = '0;
    rd_pend = '0;
    for (int i = 0; i < NR; i++) begin
      rd[i]      = mem_q[ra[i]];
      rd_pend[i] = pend_q[ra[i]];

      if (BYPASS != 0) begin
        for (int p = 0; p < NW; p++) begin
          if (wr_en[p] && (wa[p] == ra[i])) begin
            byp_hit[i] = 1'b1;
            rd[i]      = wd[p];
          end
        end
        // A retiring write clears the bit unless a new producer claims the
        // same register this cycle; then the stored bit still applies.
        if (byp_hit[i] && !(iss_en && (iss_a == ra[i]))) begin
          rd_pend[i] = 1'b0;
        end
      end

      if ((ZERO_REG != 0) && (ra[i] == '0)) begin
        rd[i]      = '0;
        rd_pend[i] = 1'b0;
      end
    end
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
// Directed self-checking bench for regfile_mp at default parameters
// (DW=32, DEPTH=64, NR=2, NW=2, ZERO_REG=1, BYPASS=1).
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int NR    = 2;
  localparam int NW    = 2;

  logic                  clk;
  logic                  rst;
  logic [NW-1:0]         we;
  logic [NW-1:0][AW-1:0] wa;
  logic [NW-1:0][DW-1:0] wd;
  logic [NR-1:0][AW-1:0] ra;
  logic [NR-1:0][DW-1:0] rd;
  logic [NR-1:0]         rd_pend;
  logic                  iss_v;
  logic [AW-1:0]         iss_a;
  logic                  clr_req;
  logic                  clr_busy;
  logic                  clr_done;

  int checks   = 0;
  int failures = 0;

  regfile_mp #(
    .DW       (DW),
    .DEPTH    (DEPTH),
    .NR       (NR),
    .NW       (NW),
    .ZERO_REG (1),
    .BYPASS   (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .ra       (ra),
    .rd       (rd),
    .rd_pend  (rd_pend),
    .iss_v    (iss_v),
    .iss_a    (iss_a),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_n;
    int done_n;
    int done_at;
    int nz_data;
    int nz_pend;

    rst     = 1'b0;
    we      = '0;
    wa      = '0;
    wd      = '0;
    ra      = '0;
    iss_v   = 1'b0;
    iss_a   = '0;
    clr_req = 1'b0;
    ra[0]   = 6'd5;
    ra[1]   = 6'd63;

    // Reset state
    #12;
    check("reset_rd0", rd[0], 0);
    check("reset_rd1", rd[1], 0);
    check("reset_pend", rd_pend, 0);
    check("reset_busy", clr_busy, 0);
    check("reset_done", clr_done, 0);
    rst = 1'b1;
    tick();

    // Both ports write r5: port 1 wins, bypassed in the same cycle
    we    = 2'b11;
    wa[0] = 6'd5;  wd[0] = 32'hDEADBEEF;
    wa[1] = 6'd5;  wd[1] = 32'h12345678;
    #1;
    check("bypass_hi_port", rd[0], 32'h12345678);
    tick();
    we = '0;
    #1;
    check("write_hi_port", rd[0], 32'h12345678);

    // Zero register ignores writes and issue marks
    we    = 2'b01;
    wa[0] = 6'd0;  wd[0] = 32'hFFFFFFFF;
    iss_v = 1'b1;  iss_a = 6'd0;
    ra[0] = 6'd0;  ra[1] = 6'd5;
    #1;
    check("r0_rd_same_cycle", rd[0], 0);
    check("r0_pend_same_cycle", rd_pend[0], 0);
    tick();
    we = '0; iss_v = 1'b0;
    #1;
    check("r0_rd_after", rd[0], 0);
    check("r0_pend_after", rd_pend[0], 0);
    check("r5_untouched", rd[1], 32'h12345678);

    // Issue r7, then write it back
    iss_v = 1'b1; iss_a = 6'd7; ra[1] = 6'd7;
    #1;
    check("r7_pend_before_edge", rd_pend[1], 0);
    tick();
    iss_v = 1'b0;
    #1;
    check("r7_pend_set", rd_pend[1], 1);
    we = 2'b01; wa[0] = 6'd7; wd[0] = 32'h000000A5;
    #1;
    check("r7_pend_bypass_clr", rd_pend[1], 0);
    check("r7_rd_bypass", rd[1], 32'hA5);
    tick();
    we = '0;
    #1;
    check("r7_pend_cleared", rd_pend[1], 0);
    check("r7_rd_stored", rd[1], 32'hA5);

    // Issue and write r9 together: pending wins
    iss_v = 1'b1; iss_a = 6'd9;
    we = 2'b10; wa[1] = 6'd9; wd[1] = 32'h99;
    ra[0] = 6'd9;
    #1;
    check("r9_rd_bypass", rd[0], 32'h99);
    check("r9_pend_same_cycle", rd_pend[0], 0);
    tick();
    we = '0; iss_v = 1'b0;
    #1;
    check("r9_pend_set_wins", rd_pend[0], 1);
    check("r9_rd_stored", rd[0], 32'h99);

    // Fill every register, two per cycle
    for (int i = 0; i < DEPTH; i += 2) begin
      we    = 2'b11;
      wa[0] = AW'(i);     wd[0] = 32'(32'h1000 + i);
      wa[1] = AW'(i + 1); wd[1] = 32'(32'h1000 + i + 1);
      tick();
    end
    we = '0;
    iss_v = 1'b1; iss_a = 6'd20;
    tick();
    iss_v = 1'b0;
    ra[0] = 6'd63; ra[1] = 6'd0;
    #1;
    check("fill_r63", rd[0], 32'h103F);
    check("fill_r0_zero", rd[1], 0);
    ra[0] = 6'd20; ra[1] = 6'd9;
    #1;
    check("fill_r20", rd[0], 32'h1014);
    check("fill_r20_pend", rd_pend[0], 1);
    check("fill_r9_pend_clr", rd_pend[1], 0);

    // Bulk clear, with writes, an issue and a repeat request during the sweep
    ra[0] = 6'd5; ra[1] = 6'd20;
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_n  = 0;
    done_n  = 0;
    done_at = 0;
    for (int c = 1; c <= 70; c++) begin
      if (c == 10) begin
        we = 2'b01; wa[0] = 6'd5; wd[0] = 32'h77;
        iss_v = 1'b1; iss_a = 6'd6;
      end
      if (c == 11) begin
        we = '0; iss_v = 1'b0;
      end
      clr_req = (c == 30);
      #1;
      if (c == 10) begin
        check("sweep_no_bypass", rd[0], 0);
        check("sweep_reads_array", rd[1], 32'h1014);
        check("sweep_pend_intact", rd_pend[1], 1);
      end
      if (clr_busy) busy_n++;
      if (clr_done) begin
        done_n++;
        if (done_at == 0) done_at = c;
      end
      @(posedge clk);
      #1;
    end
    clr_req = 1'b0;
    check("sweep_busy_cycles", busy_n, 64);
    check("sweep_done_count", done_n, 1);
    check("sweep_done_cycle", done_at, 65);

    nz_data = 0;
    nz_pend = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ra[0] = AW'(i);
      #1;
      if (rd[0] !== '0) nz_data++;
      if (rd_pend[0] !== 1'b0) nz_pend++;
    end
    check("sweep_all_data_zero", nz_data, 0);
    check("sweep_all_pend_zero", nz_pend, 0);
    ra[0] = 6'd5; ra[1] = 6'd6;
    #1;
    check("sweep_write_masked", rd[0], 0);
    check("sweep_issue_masked", rd_pend[1], 0);

    // Reset in the middle of a sweep
    tick();
    we = 2'b11; wa[0] = 6'd50; wd[0] = 32'h50; wa[1] = 6'd3; wd[1] = 32'h33;
    iss_v = 1'b1; iss_a = 6'd51;
    tick();
    we = '0; iss_v = 1'b0;
    ra[0] = 6'd50; ra[1] = 6'd51;
    #1;
    check("pre_abort_r50", rd[0], 32'h50);
    check("pre_abort_r51_pend", rd_pend[1], 1);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (20) tick();
    #1;
    check("pre_abort_busy", clr_busy, 1);
    #1;
    rst = 1'b0;
    #1;
    check("abort_busy", clr_busy, 0);
    check("abort_done", clr_done, 0);
    check("abort_r50", rd[0], 0);
    check("abort_r51_pend", rd_pend[1], 0);
    #3;
    rst = 1'b1;
    tick();
    tick();
    ra[1] = 6'd3;
    #1;
    check("post_abort_idle", clr_busy, 0);
    check("post_abort_r3", rd[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_mp
